// File: rtl/cve2_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared memory port with in-order response routing.
// Optional build macro CVE2_MEM_ARB_RR_EN selects round-robin arbitration; default is fixed data-first priority.
module cve2_mem_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic        instr_err_o,
   output logic [31:0] instr_rdata_o,

   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   output logic [31:0] data_rdata_o,

   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic        mem_err_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic {
      OwnerInstr = 1'b0,
      OwnerData  = 1'b1
   } owner_e;

   logic [2:0] count_r;
   logic [1:0] wr_ptr_r;
   logic [1:0] rd_ptr_r;
   logic [3:0] fifo_r;
   logic       lock_r;
   owner_e     lock_owner_r;

   owner_e     owner_s;
   owner_e     head_s;
   logic       full_s;
   logic       any_req_s;
   logic       handshake_s;
   logic       pop_s;
   logic       lock_live_s;

`ifdef CVE2_MEM_ARB_RR_EN
   owner_e     rr_pref_r;
`endif

   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
      if (ptr == 2'(MaxOutstanding - 1)) begin
         return 2'd0;
      end else begin
         return ptr + 2'd1;
      end
   endfunction

   // A pop in the same cycle deliberately does not lift full, keeping rvalid off the request path.
   assign full_s      = (count_r == 3'(MaxOutstanding));
   assign any_req_s   = instr_req_i | data_req_i;
   assign mem_req_o   = any_req_s & ~full_s;
   assign handshake_s = mem_req_o & mem_gnt_i;
   assign pop_s       = mem_rvalid_i & (count_r != 3'd0);
   assign head_s      = owner_e'(fifo_r[rd_ptr_r]);
   assign lock_live_s = lock_r & ((lock_owner_r == OwnerData) ? data_req_i : instr_req_i);

   // Owner selection: a pending ungranted request keeps its slot, otherwise arbitrate.
   always_comb begin
      owner_s = OwnerInstr;
      if (lock_live_s) begin
         owner_s = lock_owner_r;
      end else if (data_req_i && instr_req_i) begin
`ifdef CVE2_MEM_ARB_RR_EN
         owner_s = rr_pref_r;
`else
         owner_s = OwnerData;
`endif
      end else if (data_req_i) begin
         owner_s = OwnerData;
      end else begin
         owner_s = OwnerInstr;
      end
   end

   // Shared-port mux; instruction fetches are full-word reads.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = 32'h0000_0000;
      case (owner_s)
         OwnerData: begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
         end
         OwnerInstr: begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = 32'h0000_0000;
         end
         default: begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = 32'h0000_0000;
         end
      endcase
   end

   assign instr_gnt_o    = handshake_s & (owner_s == OwnerInstr);
   assign data_gnt_o     = handshake_s & (owner_s == OwnerData);
   assign instr_rvalid_o = pop_s & (head_s == OwnerInstr);
   assign data_rvalid_o  = pop_s & (head_s == OwnerData);
   assign instr_err_o    = instr_rvalid_o & mem_err_i;
   assign data_err_o     = data_rvalid_o & mem_err_i;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

   // In-order owner FIFO tracking granted but unanswered transactions.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_r  <= 3'd0;
         wr_ptr_r <= 2'd0;
         rd_ptr_r <= 2'd0;
         fifo_r   <= 4'd0;
      end else begin
         if (handshake_s) begin
            fifo_r[wr_ptr_r] <= owner_s;
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({handshake_s, pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Lock holds the owner while a request waits for its grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_r       <= 1'b0;
         lock_owner_r <= OwnerData;
      end else begin
         lock_r       <= mem_req_o & ~mem_gnt_i;
         lock_owner_r <= owner_s;
      end
   end

`ifdef CVE2_MEM_ARB_RR_EN
   // Round-robin pointer: the side just granted loses the next tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_pref_r <= OwnerData;
      end else if (handshake_s) begin
         rr_pref_r <= (owner_s == OwnerData) ? OwnerInstr : OwnerData;
      end else begin
         rr_pref_r <= rr_pref_r;
      end
   end
`endif

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Self-checking bench for cve2_mem_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_cve2_mem_arbiter;

   localparam int MAX = 2;

   logic        clk_i;
   logic        rst_ni;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_rdata_i;

   int checks = 0;
   int failures = 0;

   cve2_mem_arbiter #(.MaxOutstanding(MAX)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic idle_inputs();
      instr_req_i = 1'b0; instr_addr_i = 32'h0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
      data_addr_i = 32'h0; data_wdata_i = 32'h0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'h0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      idle_inputs();
      mem_rvalid_i = 1'b1;
      @(negedge clk_i); #1;
      checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
         failures++;
         $display("FAIL reset_hold: got %b want 00000",
                  {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      checks++;
      if ({mem_req_o, instr_rvalid_o, data_rvalid_o} !== 3'b0) begin
         failures++;
         $display("FAIL reset_release_empty_rvalid: got %b want 000",
                  {mem_req_o, instr_rvalid_o, data_rvalid_o});
      end
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_instr_fetch();
      instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
      #1;
      checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 32'h80}) begin
         failures++;
         $display("FAIL fetch_grant: req=%b ig=%b dg=%b we=%b be=%h addr=%h want 1 1 0 0 f 00000080",
                  mem_req_o, instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o);
      end
      @(negedge clk_i);
      idle_inputs();
      @(negedge clk_i);
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13;
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o, instr_err_o, instr_rdata_o} !== {3'b100, 32'h13}) begin
         failures++;
         $display("FAIL fetch_response: irv=%b drv=%b ierr=%b rdata=%h want 1 0 0 00000013",
                  instr_rvalid_o, data_rvalid_o, instr_err_o, instr_rdata_o);
      end
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_priority();
      logic exp_d [3];
`ifdef CVE2_MEM_ARB_RR_EN
      exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1;
`else
      exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1;
`endif
      for (int i = 0; i < 3; i++) begin
         instr_req_i = 1'b1; instr_addr_i = 32'h400;
         data_req_i = 1'b1; data_addr_i = 32'h800; data_be_i = 4'h1;
         mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'(i);
         #1;
         checks++;
         if ({instr_gnt_o, data_gnt_o} !== {~exp_d[i], exp_d[i]}) begin
            failures++;
            $display("FAIL priority_grant[%0d]: ig=%b dg=%b want %b %b",
                     i, instr_gnt_o, data_gnt_o, ~exp_d[i], exp_d[i]);
         end
         checks++;
         if (i == 0) begin
            if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
               failures++;
               $display("FAIL priority_empty_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o});
            end
         end else if ({instr_rvalid_o, data_rvalid_o} !== {~exp_d[i-1], exp_d[i-1]}) begin
            failures++;
            $display("FAIL priority_rvalid[%0d]: got %b want %b", i,
                     {instr_rvalid_o, data_rvalid_o}, {~exp_d[i-1], exp_d[i-1]});
         end
         @(negedge clk_i);
      end
      idle_inputs();
      mem_rvalid_i = 1'b1;
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {~exp_d[2], exp_d[2]}) begin
         failures++;
         $display("FAIL priority_drain: got %b want %b", {instr_rvalid_o, data_rvalid_o}, {~exp_d[2], exp_d[2]});
      end
      @(negedge clk_i);
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
         failures++;
         $display("FAIL priority_spurious_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o});
      end
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_lock();
      for (int i = 0; i < 4; i++) begin
         data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
         data_addr_i = 32'h100; data_wdata_i = 32'hDEAD_BEEF;
         instr_req_i = (i >= 1); instr_addr_i = 32'h200;
         mem_gnt_i = (i == 3);
         #1;
         checks++;
         if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, instr_gnt_o, data_gnt_o} !==
             {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 1'b0, (i == 3)}) begin
            failures++;
            $display("FAIL lock_hold[%0d]: req=%b we=%b be=%h addr=%h wd=%h ig=%b dg=%b want addr 00000100 dg=%0d",
                     i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, instr_gnt_o, data_gnt_o, (i == 3));
         end
         @(negedge clk_i);
      end
      idle_inputs();
      instr_req_i = 1'b1; instr_addr_i = 32'h200; mem_gnt_i = 1'b1;
      #1;
      checks++;
      if ({instr_gnt_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h200, 32'h0}) begin
         failures++;
         $display("FAIL lock_then_instr: ig=%b we=%b be=%h addr=%h wd=%h want 1 0 f 00000200 0",
                  instr_gnt_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
      end
      @(negedge clk_i);
      idle_inputs();
      mem_rvalid_i = 1'b1;
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
         failures++;
         $display("FAIL lock_resp0: got %b want 01", {instr_rvalid_o, data_rvalid_o});
      end
      @(negedge clk_i);
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
         failures++;
         $display("FAIL lock_resp1: got %b want 10", {instr_rvalid_o, data_rvalid_o});
      end
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_full();
      logic [2:0] exp_v [5];
      exp_v[0] = 3'b110; exp_v[1] = 3'b110; exp_v[2] = 3'b000; exp_v[3] = 3'b001; exp_v[4] = 3'b110;
      for (int i = 0; i < 5; i++) begin
         instr_req_i = 1'b1; instr_addr_i = 32'h40; mem_gnt_i = 1'b1;
         mem_rvalid_i = (i == 3);
         #1;
         checks++;
         if ({mem_req_o, instr_gnt_o, instr_rvalid_o} !== exp_v[i]) begin
            failures++;
            $display("FAIL full_cycle[%0d]: req/gnt/rvalid got %b want %b",
                     i, {mem_req_o, instr_gnt_o, instr_rvalid_o}, exp_v[i]);
         end
         @(negedge clk_i);
      end
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         mem_rvalid_i = 1'b1;
         #1;
         checks++;
         if (instr_rvalid_o !== 1'b1) begin
            failures++;
            $display("FAIL full_drain[%0d]: irv=%b want 1", i, instr_rvalid_o);
         end
         @(negedge clk_i);
      end
      idle_inputs();
   endtask

   task automatic test_err_order();
      instr_req_i = 1'b1; instr_addr_i = 32'h10; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      idle_inputs();
      data_req_i = 1'b1; data_addr_i = 32'h20; data_be_i = 4'hF; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      idle_inputs();
      mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'hAAAA_0001;
      #1;
      checks++;
      if ({instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o} !== 4'b1100) begin
         failures++;
         $display("FAIL err_first: irv/ierr/drv/derr got %b want 1100",
                  {instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o});
      end
      @(negedge clk_i);
      mem_err_i = 1'b0; mem_rdata_i = 32'hBBBB_0002;
      #1;
      checks++;
      if ({instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o, data_rdata_o} !==
          {4'b0010, 32'hBBBB_0002}) begin
         failures++;
         $display("FAIL err_second: irv/ierr/drv/derr got %b rdata=%h want 0010 bbbb0002",
                  {instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o}, data_rdata_o);
      end
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_reset_midop();
      instr_req_i = 1'b1; instr_addr_i = 32'h30; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      idle_inputs();
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
         failures++;
         $display("FAIL midop_reset_outputs: got %b want 00000",
                  {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      mem_rvalid_i = 1'b1;
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
         failures++;
         $display("FAIL midop_stale_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o});
      end
      @(negedge clk_i);
      idle_inputs();
      instr_req_i = 1'b1; instr_addr_i = 32'h34; mem_gnt_i = 1'b1;
      #1;
      checks++;
      if ({mem_req_o, instr_gnt_o} !== 2'b11) begin
         failures++;
         $display("FAIL midop_count_cleared: req/gnt got %b want 11", {mem_req_o, instr_gnt_o});
      end
      @(negedge clk_i);
      idle_inputs();
      mem_rvalid_i = 1'b1;
      #1;
      checks++;
      if (instr_rvalid_o !== 1'b1) begin
         failures++;
         $display("FAIL midop_drain: irv=%b want 1", instr_rvalid_o);
      end
      @(negedge clk_i);
      idle_inputs();
   endtask

   // Randomized traffic checked against a queue of outstanding owners (1 = data).
   task automatic test_random();
      bit q [$];
      bit lock_valid = 1'b0;
      bit lock_owner = 1'b0;
      bit pref_data = 1'b1;
      bit gi = 1'b0, gd = 1'b0;
      bit owner, exp_req, exp_hs, exp_pop, head;
      logic [31:0] exp_addr, exp_wdata;
      logic [3:0]  exp_be;
      logic        exp_we;

      rst_ni = 1'b0;
      idle_inputs();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!(instr_req_i && !gi)) begin
            instr_req_i  = ($urandom_range(0, 2) == 0);
            instr_addr_i = $urandom & 32'hFFFF_FFFC;
         end
         if (!(data_req_i && !gd)) begin
            data_req_i   = ($urandom_range(0, 2) == 0);
            data_we_i    = $urandom_range(0, 1);
            data_be_i    = 4'($urandom_range(0, 15));
            data_addr_i  = $urandom;
            data_wdata_i = $urandom;
         end
         mem_gnt_i    = ($urandom_range(0, 3) != 0);
         mem_rvalid_i = ($urandom_range(0, 2) == 0);
         mem_err_i    = ($urandom_range(0, 3) == 0);
         mem_rdata_i  = $urandom;

         exp_req = (instr_req_i || data_req_i) && (q.size() < MAX);
         if (lock_valid) owner = lock_owner;
         else if (instr_req_i && data_req_i) begin
`ifdef CVE2_MEM_ARB_RR_EN
            owner = pref_data;
`else
            owner = 1'b1;
`endif
         end else owner = data_req_i;
         exp_hs    = exp_req && mem_gnt_i;
         exp_pop   = mem_rvalid_i && (q.size() > 0);
         head      = (q.size() > 0) ? q[0] : 1'b0;
         exp_addr  = owner ? data_addr_i  : instr_addr_i;
         exp_wdata = owner ? data_wdata_i : 32'h0;
         exp_be    = owner ? data_be_i    : 4'hF;
         exp_we    = owner ? data_we_i    : 1'b0;
         #1;
         checks++;
         if ({mem_req_o, instr_gnt_o, data_gnt_o} !== {exp_req, exp_hs && !owner, exp_hs && owner}) begin
            failures++;
            $display("FAIL rand_req_gnt[%0d]: got %b want %b", cyc,
                     {mem_req_o, instr_gnt_o, data_gnt_o}, {exp_req, exp_hs && !owner, exp_hs && owner});
         end
         checks++;
         if (exp_req && ({mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o} !== {exp_addr, exp_wdata, exp_be, exp_we})) begin
            failures++;
            $display("FAIL rand_mux[%0d]: addr=%h wd=%h be=%h we=%b want %h %h %h %b", cyc,
                     mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o, exp_addr, exp_wdata, exp_be, exp_we);
         end
         checks++;
         if ({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, instr_rdata_o, data_rdata_o} !==
             {exp_pop && !head, exp_pop && head, exp_pop && !head && mem_err_i,
              exp_pop && head && mem_err_i, mem_rdata_i, mem_rdata_i}) begin
            failures++;
            $display("FAIL rand_resp[%0d]: irv=%b drv=%b ierr=%b derr=%b want %b %b %b %b", cyc,
                     instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o,
                     exp_pop && !head, exp_pop && head, exp_pop && !head && mem_err_i,
                     exp_pop && head && mem_err_i);
         end

         if (exp_pop) void'(q.pop_front());
         if (exp_hs) begin
            q.push_back(owner);
            pref_data = !owner;
         end
         lock_valid = exp_req && !mem_gnt_i;
         lock_owner = owner;
         gi = exp_hs && !owner;
         gd = exp_hs && owner;
         @(negedge clk_i);
      end
      idle_inputs();
   endtask

   initial begin
      rst_ni = 1'b0;
      idle_inputs();
      test_reset();
      test_instr_fetch();
      test_priority();
      test_lock();
      test_full();
      test_err_order();
      test_reset_midop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
